// File: rtl/tick_seq_pkg.sv
// Shared types and default sizing for the tick sequencer slice.
package tick_seq_pkg;

    localparam int unsigned DEF_CNT_W   = 26;
    localparam int unsigned DEF_BURST_W = 8;
    localparam int unsigned DEF_DIV     = 12500000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

endpackage

// File: rtl/rate_counter.sv
// Free-running divider counter: flags when it reaches limit, then wraps to zero.
module rate_counter
    import tick_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             term
);

    logic [CNT_W-1:0] count;

    assign term = (count == limit);

    always_ff @(posedge clk_in) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= term ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tick_sequencer.sv
// Programmable tick controller: configurable divisor and burst length, run/stop
// control, registered tick enable, divided square wave and burst-done pulse.
module tick_sequencer
    import tick_seq_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned BURST_W     = DEF_BURST_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic               clk_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] tick_count
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   div_reg, div_n;
    logic [BURST_W-1:0] burst_reg, burst_n;
    logic [BURST_W-1:0] count_n;
    logic               tick_n, done_n, clk_out_n;
    logic               term;
    logic               cnt_clr, cnt_en;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state == RUN) || (state == FINISH);

    // Counter is held at zero outside RUN so a start always begins a full period.
    assign cnt_clr = (state != RUN) || stop;
    assign cnt_en  = (state == RUN);

    rate_counter #(
        .CNT_W (CNT_W)
    ) u_rate_counter (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (div_reg),
        .term   (term)
    );

    always_comb begin
        state_n   = state;
        div_n     = div_reg;
        burst_n   = burst_reg;
        count_n   = tick_count;
        tick_n    = 1'b0;
        done_n    = 1'b0;
        clk_out_n = clk_out;
        unique case (state)
            IDLE: begin
                if (cfg_valid) begin
                    div_n   = cfg_div;
                    burst_n = cfg_burst;
                end
                if (start && !stop) begin
                    state_n = RUN;
                    count_n = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n   = IDLE;
                    clk_out_n = 1'b0;
                end else if (term) begin
                    tick_n    = 1'b1;
                    clk_out_n = ~clk_out;
                    count_n   = tick_count + BURST_W'(1);
                    if ((burst_reg != '0) && (count_n == burst_reg)) begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_n   = IDLE;
                clk_out_n = 1'b0;
            end
            default: begin
                state_n   = IDLE;
                clk_out_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            div_reg    <= CNT_W'(DEFAULT_DIV);
            burst_reg  <= '0;
            tick_count <= '0;
            tick       <= 1'b0;
            done       <= 1'b0;
            clk_out    <= 1'b0;
        end else begin
            state      <= state_n;
            div_reg    <= div_n;
            burst_reg  <= burst_n;
            tick_count <= count_n;
            tick       <= tick_n;
            done       <= done_n;
            clk_out    <= clk_out_n;
        end
    end

endmodule
